// File: rtl/sa_cache_pkg.sv
// ============================================================================
// sa_cache_pkg : shared widths, FSM state encoding and request record
// Revision     : 1.0
// ============================================================================
`default_nettype none

package sa_cache_pkg;

    localparam int TAG_W          = 18;
    localparam int INDEX_W        = 8;
    localparam int OFFSET_W       = 6;
    localparam int WAYS           = 4;
    localparam int WORDS_PER_LINE = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPARE   = 2'd1,
        ST_REFILL    = 2'd2,
        ST_WRITE_MEM = 2'd3
    } state_e;

    typedef struct packed {
        logic                rw;
        logic [TAG_W-1:0]    tag;
        logic [INDEX_W-1:0]  index;
        logic [OFFSET_W-1:0] offset;
        logic [31:0]         wdata;
    } req_t;

endpackage

`default_nettype wire

// File: rtl/sa_cache_plru.sv
// ============================================================================
// sa_cache_plru : victim select and tree pseudo-LRU next-state for one set
// Revision      : 1.0
// ============================================================================
`default_nettype none

module sa_cache_plru
    import sa_cache_pkg::*;
(
    input  logic [WAYS-1:0] i_valid,
    input  logic [2:0]      i_plru,      // [0]=b0 root, [1]=b1 ways 0/1, [2]=b2 ways 2/3
    input  logic            i_use_victim,
    input  logic [1:0]      i_hit_way,
    output logic [1:0]      o_victim,
    output logic [2:0]      o_plru_next
);

    logic [1:0] access_way;

    always_comb begin
        if (!i_valid[0])      o_victim = 2'd0;
        else if (!i_valid[1]) o_victim = 2'd1;
        else if (!i_valid[2]) o_victim = 2'd2;
        else if (!i_valid[3]) o_victim = 2'd3;
        else if (!i_plru[0])  o_victim = {1'b0, i_plru[1]};
        else                  o_victim = {1'b1, i_plru[2]};

        access_way = i_use_victim ? o_victim : i_hit_way;

        // Point the tree away from the way just touched.
        o_plru_next    = i_plru;
        o_plru_next[0] = ~access_way[1];
        if (!access_way[1]) o_plru_next[1] = ~access_way[0];
        else                o_plru_next[2] = ~access_way[0];
    end

endmodule

`default_nettype wire

// File: rtl/sa_cache.sv
// ============================================================================
// sa_cache : 4-way set-associative write-through, no-write-allocate cache
// Revision : 1.0
// ============================================================================
`default_nettype none

module sa_cache #(
    parameter int TAG_W    = 18,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic                i_rw,
    input  logic [TAG_W-1:0]    i_tag,
    input  logic [INDEX_W-1:0]  i_index,
    input  logic [OFFSET_W-1:0] i_offset,
    input  logic [31:0]         i_wdata,
    output logic [31:0]         o_data,
    output logic                o_hit,
    output logic                o_done,
    output logic                o_busy,
    output logic                o_mem_req,
    output logic                o_mem_rw,
    output logic [31:0]         o_mem_addr,
    output logic [31:0]         o_mem_wdata,
    input  logic                i_mem_resp,
    input  logic [511:0]        i_mem_line
);

    import sa_cache_pkg::*;

    localparam int SETS   = 1 << INDEX_W;
    localparam int LINE_W = WORDS_PER_LINE * 32;

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    logic        whit_q, whit_d;
    logic [31:0] data_q, data_d;
    logic        hit_q, hit_d;
    logic        done_q, done_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_rw_q, mem_rw_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [LINE_W-1:0] line_q  [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [WAYS-1:0]   valid_q [SETS];
    logic [2:0]        plru_q  [SETS];

    logic [WAYS-1:0] set_valid;
    logic [2:0]      set_plru;
    logic [WAYS-1:0] hit_vec;
    logic            lookup_hit;
    logic [1:0]      hit_way;
    logic [1:0]      victim;
    logic [2:0]      plru_next;
    logic [3:0]      word_sel;
    logic [8:0]      word_base;
    logic [31:0]     hit_word;
    logic [31:0]     refill_word;
    logic            line_we, word_we, plru_we, use_victim;
    logic [1:0]      unused_offset_lsbs;

    // Byte lanes within a word are never addressed; low offset bits are dropped at capture.
    assign unused_offset_lsbs = i_offset[1:0];

    assign set_valid = valid_q[req_q.index];
    assign set_plru  = plru_q[req_q.index];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign hit_vec[w] = set_valid[w] && (tag_q[req_q.index][w] == req_q.tag);
    end

    assign lookup_hit  = |hit_vec;
    assign hit_way     = {hit_vec[3] | hit_vec[2], hit_vec[3] | hit_vec[1]};
    assign word_sel    = req_q.offset[OFFSET_W-1:2];
    assign word_base   = {word_sel, 5'b0};
    assign hit_word    = line_q[req_q.index][hit_way][word_base +: 32];
    assign refill_word = i_mem_line[word_base +: 32];
    assign use_victim  = (state_q == ST_REFILL);

    sa_cache_plru u_plru (
        .i_valid      (set_valid),
        .i_plru       (set_plru),
        .i_use_victim (use_victim),
        .i_hit_way    (hit_way),
        .o_victim     (victim),
        .o_plru_next  (plru_next)
    );

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        whit_d      = whit_q;
        data_d      = data_q;
        hit_d       = hit_q;
        done_d      = 1'b0;
        mem_req_d   = mem_req_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        line_we     = 1'b0;
        word_we     = 1'b0;
        plru_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    req_d.rw     = i_rw;
                    req_d.tag    = i_tag;
                    req_d.index  = i_index;
                    req_d.offset = {i_offset[OFFSET_W-1:2], 2'b00};
                    req_d.wdata  = i_wdata;
                    state_d      = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (!req_q.rw) begin
                    if (lookup_hit) begin
                        data_d  = hit_word;
                        hit_d   = 1'b1;
                        done_d  = 1'b1;
                        plru_we = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_rw_d   = 1'b0;
                        mem_addr_d = {req_q.tag, req_q.index, {OFFSET_W{1'b0}}};
                        state_d    = ST_REFILL;
                    end
                end else begin
                    word_we     = lookup_hit;
                    plru_we     = lookup_hit;
                    whit_d      = lookup_hit;
                    mem_req_d   = 1'b1;
                    mem_rw_d    = 1'b1;
                    mem_addr_d  = {req_q.tag, req_q.index, req_q.offset};
                    mem_wdata_d = req_q.wdata;
                    state_d     = ST_WRITE_MEM;
                end
            end
            ST_REFILL: begin
                if (i_mem_resp) begin
                    line_we   = 1'b1;
                    plru_we   = 1'b1;
                    data_d    = refill_word;
                    hit_d     = 1'b0;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_WRITE_MEM: begin
                if (i_mem_resp) begin
                    hit_d     = whit_q;
                    done_d    = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            whit_q      <= 1'b0;
            data_q      <= '0;
            hit_q       <= 1'b0;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            whit_q      <= whit_d;
            data_q      <= data_d;
            hit_q       <= hit_d;
            done_q      <= done_d;
            mem_req_q   <= mem_req_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            if (line_we) valid_q[req_q.index][victim] <= 1'b1;
            if (plru_we) plru_q[req_q.index]          <= plru_next;
        end
    end

    // Payload arrays carry no reset; the valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (line_we) begin
            line_q[req_q.index][victim] <= i_mem_line;
            tag_q[req_q.index][victim]  <= req_q.tag;
        end
        if (word_we) line_q[req_q.index][hit_way][word_base +: 32] <= req_q.wdata;
    end

    assign o_data      = data_q;
    assign o_hit       = hit_q;
    assign o_done      = done_q;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_mem_req   = mem_req_q;
    assign o_mem_rw    = mem_rw_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_sa_cache.sv
// ============================================================================
// tb_sa_cache : directed self-checking bench for sa_cache
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_sa_cache;

    logic         clk;
    logic         rst;
    logic         i_req;
    logic         i_rw;
    logic [17:0]  i_tag;
    logic [7:0]   i_index;
    logic [5:0]   i_offset;
    logic [31:0]  i_wdata;
    logic [31:0]  o_data;
    logic         o_hit;
    logic         o_done;
    logic         o_busy;
    logic         o_mem_req;
    logic         o_mem_rw;
    logic [31:0]  o_mem_addr;
    logic [31:0]  o_mem_wdata;
    logic         i_mem_resp;
    logic [511:0] i_mem_line;

    int n_cmp = 0;
    int n_err = 0;

    sa_cache dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .i_rw        (i_rw),
        .i_tag       (i_tag),
        .i_index     (i_index),
        .i_offset    (i_offset),
        .i_wdata     (i_wdata),
        .o_data      (o_data),
        .o_hit       (o_hit),
        .o_done      (o_done),
        .o_busy      (o_busy),
        .o_mem_req   (o_mem_req),
        .o_mem_rw    (o_mem_rw),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_resp  (i_mem_resp),
        .i_mem_line  (i_mem_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk_line(input logic [31:0] base);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = base + 32'(i);
        return l;
    endfunction

    // Presents a request on a falling edge; returns 1 time unit after the accepting edge.
    task automatic issue(input logic rw, input logic [17:0] tag, input logic [7:0] idx,
                         input logic [5:0] off, input logic [31:0] wd);
        @(negedge clk);
        i_req = 1'b1; i_rw = rw; i_tag = tag; i_index = idx; i_offset = off; i_wdata = wd;
        @(posedge clk);
        #1 i_req = 1'b0;
    endtask

    task automatic mem_respond(input logic [511:0] line);
        i_mem_line = line;
        i_mem_resp = 1'b1;
        @(posedge clk);
        #1 i_mem_resp = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_hit(input string nm, input logic [17:0] tag, input logic [7:0] idx,
                            input logic [5:0] off, input logic [31:0] exp);
        issue(1'b0, tag, idx, off, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_done"}, 32'(o_done), 32'd1);
        chk({nm, "_hit"}, 32'(o_hit), 32'd1);
        chk({nm, "_data"}, o_data, exp);
        chk({nm, "_memreq"}, 32'(o_mem_req), 32'd0);
    endtask

    task automatic read_miss(input string nm, input logic [17:0] tag, input logic [7:0] idx,
                             input logic [5:0] off, input logic [31:0] base);
        issue(1'b0, tag, idx, off, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_memreq"}, 32'(o_mem_req), 32'd1);
        chk({nm, "_memrw"}, 32'(o_mem_rw), 32'd0);
        chk({nm, "_addr"}, o_mem_addr, {tag, idx, 6'b0});
        chk({nm, "_busy"}, 32'(o_busy), 32'd1);
        chk({nm, "_early_done"}, 32'(o_done), 32'd0);
        mem_respond(mk_line(base));
        chk({nm, "_done"}, 32'(o_done), 32'd1);
        chk({nm, "_hit"}, 32'(o_hit), 32'd0);
        chk({nm, "_data"}, o_data, base + 32'(off[5:2]));
        chk({nm, "_memreq_drop"}, 32'(o_mem_req), 32'd0);
    endtask

    task automatic write_op(input string nm, input logic [17:0] tag, input logic [7:0] idx,
                            input logic [5:0] off, input logic [31:0] wd, input logic exp_hit);
        issue(1'b1, tag, idx, off, wd);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_memreq"}, 32'(o_mem_req), 32'd1);
        chk({nm, "_memrw"}, 32'(o_mem_rw), 32'd1);
        chk({nm, "_addr"}, o_mem_addr, {tag, idx, off[5:2], 2'b00});
        chk({nm, "_wdata"}, o_mem_wdata, wd);
        mem_respond('0);
        chk({nm, "_done"}, 32'(o_done), 32'd1);
        chk({nm, "_hit"}, 32'(o_hit), 32'(exp_hit));
    endtask

    initial begin
        rst = 1'b0; i_req = 1'b0; i_rw = 1'b0; i_tag = '0; i_index = '0; i_offset = '0;
        i_wdata = '0; i_mem_resp = 1'b0; i_mem_line = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_done", 32'(o_done), 32'd0);
        chk("reset_memreq", 32'(o_mem_req), 32'd0);
        chk("reset_hit", 32'(o_hit), 32'd0);
        chk("reset_data", o_data, 32'd0);

        // Cold miss: line address 0x00004140, word 2 carries 0xDEADBEEF.
        read_miss("cold", 18'h00001, 8'h05, 6'h08, 32'hDEADBEED);
        chk("cold_abs_data", o_data, 32'hDEADBEEF);
        read_hit("rehit", 18'h00001, 8'h05, 6'h08, 32'hDEADBEEF);

        // Write hit then read back through the cache.
        write_op("wrhit", 18'h00001, 8'h05, 6'h08, 32'h12345678, 1'b1);
        chk("wrhit_abs_addr", o_mem_addr, 32'h00004148);
        read_hit("rd_after_wr", 18'h00001, 8'h05, 6'h08, 32'h12345678);
        read_hit("neighbour_word", 18'h00001, 8'h05, 6'h0C, 32'hDEADBEF0);

        // Stray memory response while idle must not complete anything.
        @(negedge clk);
        i_mem_resp = 1'b1;
        @(posedge clk);
        #1 i_mem_resp = 1'b0;
        @(negedge clk);
        chk("idle_resp_done", 32'(o_done), 32'd0);
        chk("idle_resp_busy", 32'(o_busy), 32'd0);

        // Fill set 3 with A..D into ways 0..3, touch A, then E must replace C.
        read_miss("fillA", 18'h00010, 8'h03, 6'h00, 32'hA0000000);
        read_miss("fillB", 18'h00011, 8'h03, 6'h04, 32'hB0000000);
        read_miss("fillC", 18'h00012, 8'h03, 6'h08, 32'hC0000000);
        read_miss("fillD", 18'h00013, 8'h03, 6'h3C, 32'hD0000000);
        read_hit("touchA", 18'h00010, 8'h03, 6'h00, 32'hA0000000);
        read_miss("missE", 18'h00014, 8'h03, 6'h10, 32'hE0000000);
        read_hit("A_kept", 18'h00010, 8'h03, 6'h04, 32'hA0000001);
        read_hit("B_kept", 18'h00011, 8'h03, 6'h00, 32'hB0000000);
        read_hit("D_kept", 18'h00013, 8'h03, 6'h00, 32'hD0000000);
        read_hit("E_hit", 18'h00014, 8'h03, 6'h10, 32'hE0000004);
        read_miss("C_evicted", 18'h00012, 8'h03, 6'h08, 32'hC1000000);

        // Write miss: memory write only, nothing allocated.
        write_op("wrmiss", 18'h00020, 8'h07, 6'h10, 32'hCAFEF00D, 1'b0);
        chk("wrmiss_abs_addr", o_mem_addr, 32'h000801D0);
        read_miss("rd_after_wrmiss", 18'h00020, 8'h07, 6'h10, 32'h55550000);

        // Reset in the middle of a refill.
        issue(1'b0, 18'h00030, 8'h05, 6'h00, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_pre_memreq", 32'(o_mem_req), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("rst_mid_memreq", 32'(o_mem_req), 32'd0);
        chk("rst_mid_busy", 32'(o_busy), 32'd0);
        chk("rst_mid_done", 32'(o_done), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        read_miss("post_rst", 18'h00001, 8'h05, 6'h08, 32'h77770000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sa_cache.md
# sa_cache

4-way set-associative, write-through, no-write-allocate cache sitting between a single 32-bit requester and a line-based memory. 32-bit address = 18-bit tag, 8-bit index (256 sets), 6-bit byte offset (64-byte lines, 16 words). Word-granular reads and writes. Tree pseudo-LRU replacement.

## Interface
Parameters:
- TAG_W, 18: tag width.
- INDEX_W, 8: set index width; 256 sets.
- OFFSET_W, 6: byte offset width; 64-byte line.
- TAG_W + INDEX_W + OFFSET_W = 32.
- Ways fixed at 4.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  request strobe; sampled only in IDLE.
- i_rw  in  1  0 = read, 1 = write.
- i_tag  in  18  address tag.
- i_index  in  8  set index.
- i_offset  in  6  byte offset; [5:2] selects word, [1:0] ignored.
- i_wdata  in  32  write data.
- o_data  out  32  read data, valid while o_done = 1.
- o_hit  out  1  request hit, valid while o_done = 1.
- o_done  out  1  one-cycle completion pulse.
- o_busy  out  1  state != IDLE.
- o_mem_req  out  1  memory request, held until i_mem_resp.
- o_mem_rw  out  1  0 = line read, 1 = word write.
- o_mem_addr  out  32  refill: {tag,index,6'b0}; write: {tag,index,offset[5:2],2'b0}.
- o_mem_wdata  out  32  write-through data.
- i_mem_resp  in  1  memory completion, one cycle.
- i_mem_line  in  512  refill line; word i = bits [32i+31:32i].

## Operation
- Per set: 4 ways, each with a valid bit, an 18-bit tag and 16×32 data words. Per set: 3 PLRU bits b0/b1/b2.
- FSM states: IDLE, COMPARE, REFILL, WRITE_MEM.
- IDLE: on i_req, register the request and go to COMPARE. i_req is ignored in all other states.
- COMPARE, read hit: o_data <= word, o_hit <= 1, o_done <= 1, update PLRU, go to IDLE.
- COMPARE, read miss: o_mem_req <= 1, o_mem_rw <= 0, drive the line address, go to REFILL.
- REFILL, on i_mem_resp:
  - Write the line, tag and valid into the victim way; update PLRU.
  - o_data <= requested word, o_hit <= 0, o_done <= 1.
  - Drop o_mem_req; go to IDLE.
- COMPARE, write: if hit, update the word in the hit way and update PLRU. Either way issue o_mem_req with o_mem_rw = 1, the word address and o_mem_wdata; go to WRITE_MEM.
- WRITE_MEM, on i_mem_resp: o_done <= 1, o_hit <= registered hit, drop o_mem_req, go to IDLE.
- Write miss: no allocation and no cache state change.
- Victim choice: the lowest-numbered invalid way; if all ways are valid, the PLRU way.
- PLRU victim selection: b0 = 0 selects the pair {0,1}, with b1 choosing way 0 (0) or way 1 (1). b0 = 1 selects the pair {2,3}, with b2 choosing way 2 or way 3.
- PLRU update on access to way w: b0 <= ~w[1]. If w[1] = 0, b1 <= ~w[0]; otherwise b2 <= ~w[0].
- i_mem_resp outside REFILL and WRITE_MEM is ignored.

## Timing
- Reset (async, rst low):
  - State IDLE; all valid bits and PLRU bits cleared.
  - All outputs 0, taking effect immediately, including mid-REFILL or mid-WRITE_MEM; the transaction is abandoned.
- Hit latency: accept at edge k; o_done is high for the cycle after edge k+1.
- Miss and write latency: o_mem_req rises after edge k+1. o_done is high for the cycle after the edge that samples i_mem_resp.
- o_done is a registered one-cycle pulse. A new request may be accepted on the edge that ends the o_done cycle.
- o_mem_* outputs are registered and stable while o_mem_req = 1.

## Structure
- Package sa_cache_pkg holds:
  - TAG_W, INDEX_W, OFFSET_W, WAYS = 4, WORDS_PER_LINE = 16;
  - the FSM state enum;
  - the request struct (rw, tag, index, offset, wdata).
- Sub-module sa_cache_plru: combinational victim select from {valid[3:0], plru[2:0]} plus next-PLRU computation from the accessed way.
- Tag, valid and data arrays are behavioural registers in sa_cache.

## Test plan
- Cold read miss: tag=0x00001, index=0x05, offset=0x08 → o_mem_req, o_mem_rw=0, o_mem_addr=0x00004140. Answer with word 2 = 0xDEADBEEF → o_done, o_data=0xDEADBEEF, o_hit=0.
- Repeat the same read → o_done 2 edges after accept, o_hit=1, o_data=0xDEADBEEF, o_mem_req stays 0.
- Write hit 0x12345678 to the same address:
  - Required: o_mem_req with o_mem_rw=1, o_mem_addr=0x00004148, o_mem_wdata=0x12345678.
  - After i_mem_resp, o_hit=1.
  - A subsequent read hits with 0x12345678.
- PLRU eviction on index 0x03:
  - Fill tags A,B,C,D (ways 0–3), then read A (hit), then read E (miss).
  - Required: E evicts C (way 2); a read of A hits and a read of C misses.
- Write miss to an uncached address → memory write only, o_hit=0; a following read of that address misses.
- Assert rst low during REFILL → o_mem_req, o_busy and o_done drop immediately. After release, the previously cached line misses.
